dmem_ctrl: RTL and testbench

Parametrised, handshaked data memory for the CPU's memory stage. Byte-addressed little-endian storage with 1/2/4/8-byte accesses, full-range bounds checking, and alignment checking. A registered, one-cycle response carries read data and an error flag. An optional post-reset clearing sweep guarantees deterministic contents.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_init_sweep.sv | 34 +++
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encoding,
// controller state encoding and a size-to-byte-count helper.
package dmem_pkg;

    // Access size encoding carried on req_size.
    localparam logic [1:0] SZ_B = 2'd0;  // 1 byte
    localparam logic [1:0] SZ_H = 2'd1;  // 2 bytes
    localparam logic [1:0] SZ_W = 2'd2;  // 4 bytes
    localparam logic [1:0] SZ_D = 2'd3;  // 8 bytes

    // Controller state: INIT only exists while the clearing sweep runs.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Number of bytes touched by an access of the given size code.
    function automatic int unsigned size_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_init_sweep.sv
// Clear-beat counter for the post-reset memory sweep. While active it walks
// the memory one word (2**BEAT_SHIFT bytes) per cycle from byte 0 upward and
// flags the final beat with done. Reset returns the walk to byte 0.
module dmem_init_sweep #(
    parameter int IDX_W      = 10,
    parameter int BEATS      = 128,
    parameter int BEAT_SHIFT = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             active,
    output logic [IDX_W-1:0] beat_addr,
    output logic             we,
    output logic             done
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0] cnt;

    // Beat counter: advances once per active cycle, wraps after the last beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= done ? '0 : cnt + CNT_W'(1);
        end
    end

    assign we        = active;
    assign done      = active && (cnt == CNT_W'(BEATS - 1));
    assign beat_addr = IDX_W'(cnt) << BEAT_SHIFT;

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked byte-addressed little-endian data memory for the memory stage.
// Supports 1/2/4/8-byte loads and stores with bounds and alignment checks and
// a registered one-cycle response.
// Build option: define DMEM_INIT_CLEAR_EN to clear the whole array after
// reset (INIT state) before the first request is accepted.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready
// and RST is low. Every taken request yields exactly one rsp_valid pulse on
// the following cycle; there is no response backpressure.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    state_e state;
    state_e state_n;

    logic              accept;
    logic              store_ok;
    int unsigned       nbytes;
    logic [ADDR_W:0]   nbytes_w;
    logic [ADDR_W:0]   end_addr;
    logic              err_bounds;
    logic              err_align;
    logic              err_size;
    logic              req_err;
    logic [BYTES-1:0]  byte_en;
    logic [DATA_W-1:0] load_data;

`ifdef DMEM_INIT_CLEAR_EN
    localparam int     BEATS       = DEPTH_BYTES / BYTES;
    localparam int     BEAT_SHIFT  = $clog2(BYTES);
    localparam state_e RESET_STATE = ST_INIT;

    logic             in_init;
    logic             sweep_we;
    logic             sweep_done;
    logic [IDX_W-1:0] sweep_addr;

    assign in_init = (state == ST_INIT);

    dmem_init_sweep #(
        .IDX_W      (IDX_W),
        .BEATS      (BEATS),
        .BEAT_SHIFT (BEAT_SHIFT)
    ) u_sweep (
        .CLK       (CLK),
        .RST       (RST),
        .active    (in_init),
        .beat_addr (sweep_addr),
        .we        (sweep_we),
        .done      (sweep_done)
    );
`else
    localparam state_e RESET_STATE = ST_READY;
`endif

    assign req_ready = (state == ST_READY);
    // A request coinciding with reset is ignored entirely.
    assign accept    = req_valid && req_ready && !RST;
    assign store_ok  = accept && req_write && !req_err;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RESET_STATE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: INIT hands over to READY after the final clear beat.
    always_comb begin
        state_n = state;
`ifdef DMEM_INIT_CLEAR_EN
        if (state == ST_INIT && sweep_done) begin
            state_n = ST_READY;
        end
`endif
    end

    // Request checks; the end address uses one extra bit so it cannot wrap.
    always_comb begin
        nbytes     = size_bytes(req_size);
        nbytes_w   = (ADDR_W + 1)'(nbytes);
        end_addr   = {1'b0, req_addr} + nbytes_w;
        err_bounds = end_addr > (ADDR_W + 1)'(DEPTH_BYTES);
        err_align  = ({1'b0, req_addr} & (nbytes_w - (ADDR_W + 1)'(1))) != '0;
        err_size   = (req_size == SZ_D) && (DATA_W == 32);
        req_err    = err_bounds || err_align || err_size;
        byte_en    = '0;
        for (int unsigned k = 0; k < BYTES; k++) begin
            byte_en[k] = (k < nbytes);
        end
    end

    // Little-endian gather of the addressed bytes, zero-extended.
    always_comb begin
        load_data = '0;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (byte_en[k] && !req_err) begin
                load_data[8*k +: 8] = mem[req_addr[IDX_W-1:0] + IDX_W'(k)];
            end
        end
    end

    // Byte array: clear beats during INIT, otherwise byte-enabled stores.
    always_ff @(posedge CLK) begin
`ifdef DMEM_INIT_CLEAR_EN
        if (!RST && sweep_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                mem[sweep_addr + IDX_W'(b)] <= 8'h00;
            end
        end else if (store_ok) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (byte_en[k]) begin
                    mem[req_addr[IDX_W-1:0] + IDX_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
`else
        if (store_ok) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (byte_en[k]) begin
                    mem[req_addr[IDX_W-1:0] + IDX_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
`endif
    end

    // Response register: one pulse per accepted request; data only for good loads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_error <= accept && req_err;
            rsp_rdata <= (accept && !req_write && !req_err) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: reset and INIT-length checks, a table of directed
// vectors, a short random load/store run against a byte-array reference,
// reset corner cases, and a few checks on a 32-bit instance.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int EW = 32 + 1 + 64;  // {due cycle, error, rdata}

`ifdef DMEM_INIT_CLEAR_EN
    localparam int   INIT_CYC     = 128;
    localparam logic READY_IN_RST = 1'b0;
`else
    localparam int   INIT_CYC     = 0;
    localparam logic READY_IN_RST = 1'b1;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (64-bit) ----------------
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_error;
    logic [63:0] rsp_rdata;

    dmem_ctrl u_dut (
        .CLK       (clk),
        .RST       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    // ---------------- DUT (32-bit) ----------------
    logic        v32_valid, v32_ready, v32_write;
    logic [1:0]  v32_size;
    logic [15:0] v32_addr;
    logic [31:0] v32_wdata;
    logic        v32_rsp_valid, v32_rsp_error;
    logic [31:0] v32_rsp_rdata;

    dmem_ctrl #(.DATA_W(32), .DEPTH_BYTES(1024), .ADDR_W(16)) u_dut32 (
        .CLK       (clk),
        .RST       (rst),
        .req_valid (v32_valid),
        .req_ready (v32_ready),
        .req_write (v32_write),
        .req_size  (v32_size),
        .req_addr  (v32_addr),
        .req_wdata (v32_wdata),
        .rsp_valid (v32_rsp_valid),
        .rsp_rdata (v32_rsp_rdata),
        .rsp_error (v32_rsp_error)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];
    logic [7:0] ref_mem [1024];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every rsp_valid pops one expectation, which must be
    // due on exactly this cycle; an expectation left past its cycle is missing.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rsp_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d, expected no response", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e[96:65] != 32'(cyc) || rsp_error !== e[64] || rsp_rdata !== e[63:0]) begin
                    n_fail++;
                    $display("FAIL rsp: got cyc=%0d err=%0b rdata=0x%0h expected cyc=%0d err=%0b rdata=0x%0h",
                             cyc, rsp_error, rsp_rdata, e[96:65], e[64], e[63:0]);
                end
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0][96:65]) <= cyc) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL rsp_missing: got rsp_valid=0 at cycle %0d expected err=%0b rdata=0x%0h",
                     cyc, e[64], e[63:0]);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; the request is taken on the next edge.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [15:0] addr,
                        input logic [63:0] wd, input logic eerr, input logic [63:0] erd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        exp_q.push_back({32'(cyc + 1), eerr, erd});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send32(input string name, input logic wr, input logic [1:0] sz,
                          input logic [15:0] addr, input logic [31:0] wd,
                          input logic eerr, input logic [31:0] erd);
        v32_valid = 1'b1;
        v32_write = wr;
        v32_size  = sz;
        v32_addr  = addr;
        v32_wdata = wd;
        @(posedge clk);
        #1;
        v32_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (v32_rsp_valid !== 1'b1 || v32_rsp_error !== eerr || v32_rsp_rdata !== erd) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b err=%0b rdata=0x%0h expected valid=1 err=%0b rdata=0x%0h",
                     name, v32_rsp_valid, v32_rsp_error, v32_rsp_rdata, eerr, erd);
        end
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with req_ready low, starting at the next falling edge.
    task automatic wait_ready(output int lows);
        lows = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && lows < 1000) begin
            lows++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [15:0] addr;
        logic [63:0] wd;
        logic        err;
        logic [63:0] rd;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    initial begin
        int          lows;
        int          nb;
        int          a;
        logic        wr;
        logic [1:0]  sz;
        logic [15:0] addr;
        logic [63:0] wd;
        logic [63:0] erd;

        vecs[0]  = '{1'b0, SZ_D, 16'h0040, 64'h0, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, SZ_D, 16'h0010, 64'h1122334455667788, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, SZ_B, 16'h0010, 64'h0, 1'b0, 64'h88};
        vecs[3]  = '{1'b0, SZ_B, 16'h0017, 64'h0, 1'b0, 64'h11};
        vecs[4]  = '{1'b0, SZ_W, 16'h0014, 64'h0, 1'b0, 64'h11223344};
        vecs[5]  = '{1'b0, SZ_H, 16'h0012, 64'h0, 1'b0, 64'h5566};
        vecs[6]  = '{1'b1, SZ_H, 16'h0020, 64'hBEEF, 1'b0, 64'h0};
        vecs[7]  = '{1'b0, SZ_H, 16'h0020, 64'h0, 1'b0, 64'hBEEF};
        vecs[8]  = '{1'b0, SZ_D, 16'h03F8, 64'h0, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, SZ_D, 16'h03FC, 64'h0, 1'b1, 64'h0};
        vecs[10] = '{1'b1, SZ_W, 16'h0402, 64'hDEADBEEF, 1'b1, 64'h0};
        vecs[11] = '{1'b1, SZ_W, 16'h0400, 64'hDEADBEEF, 1'b1, 64'h0};
        vecs[12] = '{1'b0, SZ_W, 16'h0000, 64'h0, 1'b0, 64'h0};
        vecs[13] = '{1'b0, SZ_B, 16'h0400, 64'h0, 1'b1, 64'h0};
        vecs[14] = '{1'b1, SZ_W, 16'h0022, 64'hCAFEF00D, 1'b1, 64'h0};
        vecs[15] = '{1'b0, SZ_W, 16'h0020, 64'h0, 1'b0, 64'h0000BEEF};
        vecs[16] = '{1'b0, SZ_H, 16'h0021, 64'h0, 1'b1, 64'h0};
        vecs[17] = '{1'b1, SZ_B, 16'h0021, 64'hFFFFFFFFFFFFFFAA, 1'b0, 64'h0};
        vecs[18] = '{1'b0, SZ_W, 16'h0020, 64'h0, 1'b0, 64'h0000AAEF};
        vecs[19] = '{1'b1, SZ_D, 16'h03F8, 64'h0102030405060708, 1'b0, 64'h0};
        vecs[20] = '{1'b0, SZ_D, 16'h03F8, 64'h0, 1'b0, 64'h0102030405060708};
        vecs[21] = '{1'b0, SZ_B, 16'h03FF, 64'h0, 1'b0, 64'h01};
        vecs[22] = '{1'b0, SZ_D, 16'h03F9, 64'h0, 1'b1, 64'h0};
        vecs[23] = '{1'b0, SZ_H, 16'hFFFE, 64'h0, 1'b1, 64'h0};
        vecs[24] = '{1'b0, SZ_D, 16'h0010, 64'h0, 1'b0, 64'h1122334455667788};
        vecs[25] = '{1'b1, SZ_D, 16'h0018, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0};
        vecs[26] = '{1'b0, SZ_W, 16'h03FC, 64'h0, 1'b0, 64'h01020304};
        // vecs[25]: 8B store at 0x18 is aligned and in range, so not an error
        vecs[25].err = 1'b0;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        v32_valid = 1'b0; v32_write = 1'b0; v32_size = 2'd0; v32_addr = '0; v32_wdata = '0;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_error", 64'(rsp_error), 64'h0);
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'(READY_IN_RST));

        // INIT length after reset release.
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(lows);
        check("init_len", 64'(lows), 64'(INIT_CYC));
        check("init_len32_ready", 64'(v32_ready), 64'h1);
        @(posedge clk);
        #1;

`ifndef DMEM_INIT_CLEAR_EN
        // Without the sweep, give the array known contents first.
        for (int i = 0; i < 128; i++) send(1'b1, SZ_D, 16'(i * 8), 64'h0, 1'b0, 64'h0);
`endif

        // Directed table, issued back to back.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].rd);
        end

        // Random aligned traffic in 0x100..0x1FF against the reference array.
        for (int i = 0; i < 60; i++) begin
            sz   = 2'($urandom_range(0, 3));
            nb   = 1 << sz;
            a    = $urandom_range(0, 255);
            a    = a - (a % nb);
            addr = 16'(256 + a);
            wr   = 1'($urandom_range(0, 1));
            wd   = {$urandom(), $urandom()};
            erd  = '0;
            if (wr) begin
                for (int k = 0; k < nb; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < nb; k++) erd[8*k +: 8] = ref_mem[int'(addr) + k];
            end
            send(wr, sz, addr, wd, 1'b0, erd);
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset on the same edge as a store: ignored, no response.
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_D;
        req_addr = 16'h0030; req_wdata = 64'hFFFFFFFFFFFFFFFF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_edge_no_rsp", 64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(lows);
        check("init_len_2", 64'(lows), 64'(INIT_CYC));
        @(posedge clk);
        #1;
        send(1'b0, SZ_D, 16'h0030, 64'h0, 1'b0, 64'h0);

        // Reset 50 cycles into the sweep restarts it; a request held while
        // not ready is never taken.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_D;
        req_addr = 16'h0050; req_wdata = 64'hA5A5A5A5A5A5A5A5;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(lows);
        req_valid = 1'b0;
        check("init_restart_len", 64'(lows), 64'(INIT_CYC));
        @(posedge clk);
        #1;
        send(1'b0, SZ_D, 16'h0050, 64'h0, 1'b0, 64'h0);

        // 32-bit instance.
        send32("w32_store4", 1'b1, SZ_W, 16'h0000, 32'hA5A55A5A, 1'b0, 32'h0);
        send32("w32_load4", 1'b0, SZ_W, 16'h0000, 32'h0, 1'b0, 32'hA5A55A5A);
        send32("w32_load1", 1'b0, SZ_B, 16'h0003, 32'h0, 1'b0, 32'hA5);
        send32("w32_load2", 1'b0, SZ_H, 16'h0002, 32'h0, 1'b0, 32'hA5A5);
        send32("w32_load8_err", 1'b0, SZ_D, 16'h0000, 32'h0, 1'b1, 32'h0);
        send32("w32_store8_err", 1'b1, SZ_D, 16'h0000, 32'hFFFFFFFF, 1'b1, 32'h0);
        send32("w32_after_err", 1'b0, SZ_W, 16'h0000, 32'h0, 1'b0, 32'hA5A55A5A);

        // Drain and report.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1, "timeout");
    end

endmodule
